uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `pclk` is the clock and `rst` is the reset.
REQ-002 `pclk  in  1` — system clock; all state SHALL update on its rising edge.
REQ-003 `rst  in  1` — asynchronous, active-high reset.
REQ-004 `rx  in  1` — serial line input, asynchronous to `pclk`, idle high.
REQ-005 `rxclk_en  in  1` — one-`pclk` strobe at 16x the baud rate, from the baud-rate generator.
REQ-006 `rdy_clr  in  1` — consumer acknowledge; clears `rdy`.
REQ-007 `data  out  8` — last received byte.
REQ-008 `rdy  out  1` — byte available, sticky until `rdy_clr`.
REQ-009 `frame_err  out  1` — last frame had a low stop bit.
REQ-010 `overrun  out  1` — a byte completed while `rdy` was already 1; sticky until `rdy_clr`.
REQ-011 `parity_err  out  1` — parity mismatch on the last frame; constant 0 when parity is not compiled in.

Function
REQ-012 `rx` SHALL pass through a 2-flop synchronizer; every rule below refers to the synchronized value, `rx_s`.
REQ-013 The state machine SHALL have states IDLE, START, DATA, PARITY and STOP, plus a 4-bit tick counter `cnt` and a 3-bit bit index.
REQ-014 `cnt` and all state transitions SHALL advance only in cycles where `rxclk_en`=1; state SHALL hold in all other cycles.
REQ-015 IDLE: on a tick with `rx_s`=0, go to START with `cnt`=0.
REQ-016 START: on the tick where `cnt`=7 (mid start bit), go to DATA with `cnt`=0 and bit index 0 if `rx_s`=0; if `rx_s`=1, treat it as a glitch and return to IDLE.
REQ-017 DATA: on each tick where `cnt`=15, shift `rx_s` into a shift register LSB-first (shift right, new bit into bit 7) and increment the bit index.
REQ-018 DATA exit: after the 8th bit, go to PARITY if parity is compiled in, otherwise to STOP.
REQ-019 `cnt` SHALL wrap from 15 to 0.
REQ-020 STOP: on the tick where `cnt`=15, load `data` from the shift register and return to IDLE.
REQ-021 STOP with `rx_s`=1: set `rdy`=1 and `frame_err`=0.
REQ-022 STOP with `rx_s`=0: set `frame_err`=1 and leave `rdy` unchanged.
REQ-023 Overrun: if `rdy` is already 1 when a valid stop bit is sampled, `data` SHALL be overwritten and `overrun` set to 1.
REQ-024 Latency: `rdy` SHALL be 1 in the `pclk` cycle after the stop-bit sampling tick.
REQ-025 `rdy_clr`=1 SHALL clear `rdy` and `overrun` in the next cycle.
REQ-026 If `rdy_clr` and a set of `rdy` occur in the same cycle, the set SHALL win.
REQ-027 A low level seen in IDLE immediately after STOP SHALL start a new frame with no dead ticks.

Reset
REQ-028 When `rst` is asserted: state=IDLE, `cnt`=0, bit index=0, shift register=0, both synchronizer flops=1.
REQ-029 When `rst` is asserted, all outputs SHALL be 0: `data`, `rdy`, `frame_err`, `overrun`, `parity_err`.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no `rdy` pulse; after release, reception SHALL wait for a fresh start bit.

Configuration
REQ-031 The macro `UART_RX_PARITY_EN` SHALL compile the PARITY state in or out.
REQ-032 With the macro defined: PARITY samples a 9th bit at `cnt`=15, then goes to STOP.
REQ-033 With the macro defined: at STOP, `parity_err` SHALL be set to (XOR of the 8 data bits XOR the parity bit) — even parity — and updated at the same time as `data`.
REQ-034 Without the macro: the frame is 8N1, PARITY is unreachable, and `parity_err` is tied to 0.

Structure
REQ-035 A shared package `uart_pkg` SHALL hold the state encoding and the constants DATA_BITS=8, OVERSAMPLE=16 and MID_TICK=7.
REQ-036 No sub-module SHALL be used; the synchronizer stays inline.

Verification
REQ-037 With `rxclk_en` strobed every 4 `pclk`, an 8N1 frame of 0xA5 (64 `pclk` per bit) SHALL give `data`=0xA5, `rdy`=1 and `frame_err`=0.
REQ-038 A low glitch of 3 ticks on idle `rx` SHALL return the block to IDLE with no `rdy` and no `data` change.
REQ-039 Byte 0x3C with the stop bit held low SHALL give `frame_err`=1, `rdy`=0 and `data`=0x3C.
REQ-040 Bytes 0x11 then 0x22 sent back-to-back without `rdy_clr` SHALL give `data`=0x22 and `overrun`=1; a following `rdy_clr` pulse SHALL clear both `rdy` and `overrun`.
REQ-041 `rst` asserted during data bit 4 of 0xFF, then a frame of 0x0F, SHALL give only `data`=0x0F with `rdy`=1.
REQ-042 With `UART_RX_PARITY_EN` defined, 0x07 with parity bit 0 SHALL give `parity_err`=1, and with parity bit 1 SHALL give `parity_err`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: state encoding and framing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

endpackage

// File: rtl/uart_rx.sv
// uart_rx - 16x oversampling UART receiver, 8 data bits, LSB first.
//
// Ports:
//   pclk       in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx         in   serial line (asynchronous, idle high)
//   rxclk_en   in   one-pclk strobe at 16x baud rate
//   rdy_clr    in   consumer acknowledge, clears rdy and overrun
//   data       out  last received byte
//   rdy        out  byte available (sticky until rdy_clr)
//   frame_err  out  last frame had a low stop bit
//   overrun    out  byte completed while rdy was still set (sticky until rdy_clr)
//   parity_err out  even-parity mismatch on the last frame
//
// Build option: define UART_RX_PARITY_EN to receive a 9th (even parity) bit
// between the data bits and the stop bit. Without it the frame is 8N1 and
// parity_err is tied low.
module uart_rx
  import uart_pkg::*;
(
  input  logic       pclk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rxclk_en,
  input  logic       rdy_clr,
  output logic [7:0] data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [3:0] CNT_MID  = 4'(MID_TICK);
  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  logic       rx_meta, rx_s;
  rx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;

  logic [7:0] data_d;
  logic       rdy_d, frame_err_d, overrun_d;
  logic       stop_tick;

`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
  logic       parity_err_d;
`endif

  // State register, including the registered outputs
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data      <= data_d;
      rdy       <= rdy_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_q      <= par_d;
      parity_err <= parity_err_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Next-state logic: everything holds unless rxclk_en is high
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (rxclk_en) begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (!rx_s) state_d = ST_START;
        end
        ST_START: begin
          if (cnt_q == CNT_MID) begin
            // Re-check mid start bit; a high level here was only a glitch
            cnt_d = '0;
            if (!rx_s) begin
              state_d = ST_DATA;
              idx_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            par_d   = rx_s;
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: results are committed on the stop-bit sampling tick
  always_comb begin
    stop_tick   = rxclk_en && (state_q == ST_STOP) && (cnt_q == CNT_LAST);
    data_d      = data;
    // A new byte arriving in the same cycle as rdy_clr overrides the clear
    rdy_d       = rdy & ~rdy_clr;
    overrun_d   = overrun & ~rdy_clr;
    frame_err_d = frame_err;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err;
`endif
    if (stop_tick) begin
      data_d = shreg_q;
`ifdef UART_RX_PARITY_EN
      parity_err_d = (^shreg_q) ^ par_q;
`endif
      if (rx_s) begin
        rdy_d       = 1'b1;
        frame_err_d = 1'b0;
        if (rdy) overrun_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT_CYC = 64;  // rxclk_en every 4 pclk, 16 ticks per bit

  logic       pclk = 1'b0;
  logic       rst, rx, rxclk_en, rdy_clr;
  logic [7:0] data;
  logic       rdy, frame_err, overrun, parity_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned div   = 0;

  // Reference model of the visible receiver state
  logic [7:0] m_data;
  logic       m_rdy, m_fe, m_ovr, m_pe;

  uart_rx dut (
    .pclk       (pclk),
    .rst        (rst),
    .rx         (rx),
    .rxclk_en   (rxclk_en),
    .rdy_clr    (rdy_clr),
    .data       (data),
    .rdy        (rdy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 pclk = ~pclk;

  initial begin
    rxclk_en = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      rxclk_en = (div == 3);
      div = (div + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_data = '0;
    m_rdy  = 1'b0;
    m_fe   = 1'b0;
    m_ovr  = 1'b0;
    m_pe   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},       {24'd0, data},       {24'd0, m_data});
    check({tag, ".rdy"},        {31'd0, rdy},        {31'd0, m_rdy});
    check({tag, ".frame_err"},  {31'd0, frame_err},  {31'd0, m_fe});
    check({tag, ".overrun"},    {31'd0, overrun},    {31'd0, m_ovr});
    check({tag, ".parity_err"}, {31'd0, parity_err}, {31'd0, m_pe});
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    cycles(1);
    rdy_clr = 1'b0;
    cycles(1);
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Transmit one whole frame on rx and update the model with the outcome
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    rx = 1'b0;
    cycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(BIT_CYC);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    cycles(BIT_CYC);
`endif
    rx = stop;
    cycles(BIT_CYC);
    rx = 1'b1;
    m_data = b;
    if (stop) begin
      if (m_rdy) m_ovr = 1'b1;
      m_rdy = 1'b1;
      m_fe  = 1'b0;
    end else begin
      m_fe = 1'b1;
    end
`ifdef UART_RX_PARITY_EN
    m_pe = (^b) ^ par;
`else
    m_pe = 1'b0 & par;
`endif
  endtask

  initial begin
    logic [7:0] b;
    logic       stop, par;

    rst     = 1'b1;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    model_reset();
    cycles(5);
    check_all("reset");
    rst = 1'b0;
    cycles(100);

    // Clean 8N1 frame
    send_frame(8'hA5, 1'b0, 1'b1);
    check_all("a5");
    pulse_clr();
    check_all("a5_clr");

    // Short low glitch on the idle line
    rx = 1'b0;
    cycles(12);
    rx = 1'b1;
    cycles(3 * BIT_CYC);
    check_all("glitch");

    // Framing error: stop bit low
    send_frame(8'h3C, 1'b0, 1'b0);
    cycles(BIT_CYC);
    check_all("ferr");

    // Back-to-back frames without acknowledge
    send_frame(8'h11, 1'b0, 1'b1);
    check_all("b2b_1");
    send_frame(8'h22, 1'b0, 1'b1);
    check_all("b2b_2");
    pulse_clr();
    check_all("b2b_clr");
    cycles(BIT_CYC);

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    cycles(BIT_CYC);
    rx = 1'b1;
    cycles(4 * BIT_CYC + BIT_CYC / 2);
    rst = 1'b1;
    model_reset();
    cycles(4);
    check_all("midrst");
    rst = 1'b0;
    cycles(BIT_CYC / 2 - 4 + 5 * BIT_CYC);
    check_all("midrst_idle");
    send_frame(8'h0F, 1'b0, 1'b1);
    check_all("after_rst");
    pulse_clr();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    check_all("par0");
    pulse_clr();
    send_frame(8'h07, 1'b1, 1'b1);
    check_all("par1");
    pulse_clr();
`endif

    // Randomized frames, occasional acknowledges, bad stops and gaps
    for (int k = 0; k < 24; k++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      par  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) pulse_clr();
      send_frame(b, par, stop);
      check_all($sformatf("rnd%0d", k));
      if (!stop) cycles(BIT_CYC);
      else cycles(BIT_CYC * $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
